fft_butterfly_ctrl: RTL and testbench

- Radix-2 DIT butterfly for the 8-point FFT stages. Wraps the shared-multiplier twiddle multiplier and drives its operand ports from an internal twiddle ROM.
- Consumes the multiplier's twiddled result and produces top = A + W·B and bottom = A − W·B, scaled by 1/4.
- Sits between the stage address/RAM sequencer (upstream) and the twiddle multiplier (beside it). Exactly one butterfly is in flight at a time.

---
 rtl/fft_butterfly_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_fft_butterfly_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fft_butterfly_ctrl.sv
// Radix-2 DIT butterfly controller for the 8-point FFT.
// It latches operands A, B and the twiddle index k. It drives the shared twiddle
// multiplier from an internal ROM and waits for the twiddled result.
// It then produces (A + W*B)/4 and (A - W*B)/4.
// Optional feature macro: BFLY_TRIVIAL_BYPASS_EN. When defined, k=0 skips the
// multiplier and loads B/2 straight into the twiddle register.
module fft_butterfly_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic [1:0] i_k,
    input  logic [7:0] i_a_re,
    input  logic [7:0] i_a_im,
    input  logic [7:0] i_b_re,
    input  logic [7:0] i_b_im,
    output logic       o_busy,
    output logic       o_tw_start,
    output logic [7:0] o_tw_x,
    output logic [7:0] o_tw_y,
    output logic [7:0] o_tw_c,
    output logic [8:0] o_tw_c_plus_s,
    output logic [8:0] o_tw_c_minus_s,
    input  logic [7:0] i_tw_re,
    input  logic [7:0] i_tw_im,
    input  logic       i_tw_valid,
    output logic [7:0] o_top_re,
    output logic [7:0] o_top_im,
    output logic [7:0] o_bot_re,
    output logic [7:0] o_bot_im,
    output logic       o_valid
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT_TW = 2'd1;
    localparam logic [1:0] S_SUM     = 2'd2;

    logic [1:0] state_q, state_d;
    logic [7:0] a_re_q, a_re_d, a_im_q, a_im_d;
    logic [7:0] tw_x_q, tw_x_d, tw_y_q, tw_y_d;
    logic [7:0] tw_c_q, tw_c_d;
    logic [8:0] tw_cps_q, tw_cps_d, tw_cms_q, tw_cms_d;
    logic       tw_start_q, tw_start_d;
    logic [7:0] tw_re_q, tw_re_d, tw_im_q, tw_im_d;
    logic [7:0] top_re_q, top_re_d, top_im_q, top_im_d;
    logic [7:0] bot_re_q, bot_re_d, bot_im_q, bot_im_d;
    logic       valid_q, valid_d;

    logic [7:0] rom_c;
    logic [8:0] rom_cps, rom_cms;
    logic [9:0] top_re_full, top_im_full, bot_re_full, bot_im_full;

    // Twiddle ROM: W^k = c + j*s with s = -sin(2*pi*k/8), in Q1.7.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        rom_c   = 8'sd127;
        rom_cps = 9'sd127;
        rom_cms = 9'sd127;
        case (i_k)
            2'd1: begin rom_c = 8'sd91;  rom_cps = 9'sd0;    rom_cms = 9'sd182; end
            2'd2: begin rom_c = 8'sd0;   rom_cps = -9'sd127; rom_cms = 9'sd127; end
            2'd3: begin rom_c = -8'sd91; rom_cps = -9'sd182; rom_cms = 9'sd0;   end
            default: ;
        endcase
    end

    // Full-precision sums: sext10(A) +/- 2*sext10(tw); |result| <= 309 fits 10 bits.
    always_comb begin
        top_re_full = {{2{a_re_q[7]}}, a_re_q} + {tw_re_q[7], tw_re_q, 1'b0};
        top_im_full = {{2{a_im_q[7]}}, a_im_q} + {tw_im_q[7], tw_im_q, 1'b0};
        bot_re_full = {{2{a_re_q[7]}}, a_re_q} - {tw_re_q[7], tw_re_q, 1'b0};
        bot_im_full = {{2{a_im_q[7]}}, a_im_q} - {tw_im_q[7], tw_im_q, 1'b0};
    end

    // Next-state and next-register logic for the IDLE -> WAIT_TW -> SUM sequence.
    always_comb begin
        state_d    = state_q;
        a_re_d     = a_re_q;
        a_im_d     = a_im_q;
        tw_x_d     = tw_x_q;
        tw_y_d     = tw_y_q;
        tw_c_d     = tw_c_q;
        tw_cps_d   = tw_cps_q;
        tw_cms_d   = tw_cms_q;
        tw_re_d    = tw_re_q;
        tw_im_d    = tw_im_q;
        top_re_d   = top_re_q;
        top_im_d   = top_im_q;
        bot_re_d   = bot_re_q;
        bot_im_d   = bot_im_q;
        tw_start_d = 1'b0;
        valid_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    a_re_d   = i_a_re;
                    a_im_d   = i_a_im;
                    tw_x_d   = i_b_re;
                    tw_y_d   = i_b_im;
                    tw_c_d   = rom_c;
                    tw_cps_d = rom_cps;
                    tw_cms_d = rom_cms;
`ifdef BFLY_TRIVIAL_BYPASS_EN
                    if (i_k == 2'd0) begin
                        // W^0 = 1, so the multiplier would just return B/2.
                        tw_re_d = {i_b_re[7], i_b_re[7:1]};
                        tw_im_d = {i_b_im[7], i_b_im[7:1]};
                        state_d = S_SUM;
                    end else begin
                        tw_start_d = 1'b1;
                        state_d    = S_WAIT_TW;
                    end
`else
                    tw_start_d = 1'b1;
                    state_d    = S_WAIT_TW;
`endif
                end
            end
            S_WAIT_TW: begin
                if (i_tw_valid) begin
                    tw_re_d = i_tw_re;
                    tw_im_d = i_tw_im;
                    state_d = S_SUM;
                end
            end
            S_SUM: begin
                top_re_d = top_re_full[9:2];
                top_im_d = top_im_full[9:2];
                bot_re_d = bot_re_full[9:2];
                bot_im_d = bot_im_full[9:2];
                valid_d  = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            a_re_q     <= '0;
            a_im_q     <= '0;
            tw_x_q     <= '0;
            tw_y_q     <= '0;
            tw_c_q     <= '0;
            tw_cps_q   <= '0;
            tw_cms_q   <= '0;
            tw_start_q <= 1'b0;
            tw_re_q    <= '0;
            tw_im_q    <= '0;
            top_re_q   <= '0;
            top_im_q   <= '0;
            bot_re_q   <= '0;
            bot_im_q   <= '0;
            valid_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop take its value from the pre-edge state, with no ordering races between flops.
            state_q    <= state_d;
            a_re_q     <= a_re_d;
            a_im_q     <= a_im_d;
            tw_x_q     <= tw_x_d;
            tw_y_q     <= tw_y_d;
            tw_c_q     <= tw_c_d;
            tw_cps_q   <= tw_cps_d;
            tw_cms_q   <= tw_cms_d;
            tw_start_q <= tw_start_d;
            tw_re_q    <= tw_re_d;
            tw_im_q    <= tw_im_d;
            top_re_q   <= top_re_d;
            top_im_q   <= top_im_d;
            bot_re_q   <= bot_re_d;
            bot_im_q   <= bot_im_d;
            valid_q    <= valid_d;
        end
    end

    assign o_busy         = (state_q != S_IDLE);
    assign o_tw_start     = tw_start_q;
    assign o_tw_x         = tw_x_q;
    assign o_tw_y         = tw_y_q;
    assign o_tw_c         = tw_c_q;
    assign o_tw_c_plus_s  = tw_cps_q;
    assign o_tw_c_minus_s = tw_cms_q;
    assign o_top_re       = top_re_q;
    assign o_top_im       = top_im_q;
    assign o_bot_re       = bot_re_q;
    assign o_bot_im       = bot_im_q;
    assign o_valid        = valid_q;

endmodule

// File: tb/tb_fft_butterfly_ctrl.sv
// Directed self-checking bench for fft_butterfly_ctrl with a hand-driven mock multiplier.
// Honours BFLY_TRIVIAL_BYPASS_EN when compiled with the same macro as the RTL.
module tb_fft_butterfly_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_start;
    logic [1:0] i_k;
    logic [7:0] i_a_re, i_a_im, i_b_re, i_b_im;
    logic       o_busy, o_tw_start;
    logic [7:0] o_tw_x, o_tw_y, o_tw_c;
    logic [8:0] o_tw_c_plus_s, o_tw_c_minus_s;
    logic [7:0] i_tw_re, i_tw_im;
    logic       i_tw_valid;
    logic [7:0] o_top_re, o_top_im, o_bot_re, o_bot_im;
    logic       o_valid;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fft_butterfly_ctrl dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_k(i_k),
        .i_a_re(i_a_re), .i_a_im(i_a_im), .i_b_re(i_b_re), .i_b_im(i_b_im),
        .o_busy(o_busy), .o_tw_start(o_tw_start),
        .o_tw_x(o_tw_x), .o_tw_y(o_tw_y), .o_tw_c(o_tw_c),
        .o_tw_c_plus_s(o_tw_c_plus_s), .o_tw_c_minus_s(o_tw_c_minus_s),
        .i_tw_re(i_tw_re), .i_tw_im(i_tw_im), .i_tw_valid(i_tw_valid),
        .o_top_re(o_top_re), .o_top_im(o_top_im),
        .o_bot_re(o_bot_re), .o_bot_im(o_bot_im), .o_valid(o_valid)
    );

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_results(input string tag, input int tr, input int ti,
                                 input int br, input int bi);
        check({tag, " top_re"}, $signed(o_top_re), tr);
        check({tag, " top_im"}, $signed(o_top_im), ti);
        check({tag, " bot_re"}, $signed(o_bot_re), br);
        check({tag, " bot_im"}, $signed(o_bot_im), bi);
    endtask

    initial begin
        rst_n = 1'b0; i_start = 1'b0; i_k = 2'd0;
        i_a_re = 8'd0; i_a_im = 8'd0; i_b_re = 8'd0; i_b_im = 8'd0;
        i_tw_re = 8'd0; i_tw_im = 8'd0; i_tw_valid = 1'b0;
        tick(); tick();
        check("rst busy", o_busy, 0);
        check("rst valid", o_valid, 0);
        check("rst tw_start", o_tw_start, 0);
        check("rst tw_c", $signed(o_tw_c), 0);
        check("rst tw_cps", $signed(o_tw_c_plus_s), 0);
        check_results("rst", 0, 0, 0, 0);
        rst_n = 1'b1;
        tick();

`ifndef BFLY_TRIVIAL_BYPASS_EN
        // k=0 on the multiplier path, A=(64,0), B=(62,0), mock returns (31,0).
        i_start = 1'b1; i_k = 2'd0;
        i_a_re = 8'd64; i_a_im = 8'd0; i_b_re = 8'd62; i_b_im = 8'd0;
        tick();
        i_start = 1'b0;
        check("k0 tw_start", o_tw_start, 1);
        check("k0 busy", o_busy, 1);
        check("k0 tw_x", $signed(o_tw_x), 62);
        check("k0 tw_c", $signed(o_tw_c), 127);
        check("k0 tw_cps", $signed(o_tw_c_plus_s), 127);
        check("k0 tw_cms", $signed(o_tw_c_minus_s), 127);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("k0 tw_start low", o_tw_start, 0);
            check("k0 no early valid", o_valid, 0);
        end
        i_tw_valid = 1'b1; i_tw_re = 8'd31; i_tw_im = 8'd0;
        tick();
        i_tw_valid = 1'b0;
        check("k0 valid at tv", o_valid, 0);
        tick();
        check("k0 valid at tv+1", o_valid, 1);
        check("k0 busy done", o_busy, 0);
        // top = (64+62)>>2 = 31, bot = (64-62)>>2 = 0
        check_results("k0", 31, 0, 0, 0);
        tick();
        check("k0 valid single", o_valid, 0);
        check_results("k0 hold", 31, 0, 0, 0);
`else
        // Bypass: k=0, A=(0,0), B=(100,-3): tw=(50,-2) because -3>>>1 = -2.
        // top = (100>>2, -4>>2) = (25,-1); bot = (-100>>2, 4>>2) = (-25,1).
        i_start = 1'b1; i_k = 2'd0;
        i_a_re = 8'd0; i_a_im = 8'd0; i_b_re = 8'd100; i_b_im = -8'sd3;
        tick();
        i_start = 1'b0;
        check("byp tw_start", o_tw_start, 0);
        check("byp busy", o_busy, 1);
        check("byp valid t0", o_valid, 0);
        check("byp tw_x", $signed(o_tw_x), 100);
        check("byp tw_y", $signed(o_tw_y), -3);
        check("byp tw_c", $signed(o_tw_c), 127);
        tick();
        check("byp valid t0+1", o_valid, 1);
        check("byp tw_start2", o_tw_start, 0);
        check_results("byp", 25, -1, -25, 1);
        tick();
        check("byp valid single", o_valid, 0);
        check("byp busy done", o_busy, 0);
`endif

        // k=1, A=(-128,-128), B=(10,-20); then an ignored restart while in WAIT_TW.
        i_start = 1'b1; i_k = 2'd1;
        i_a_re = 8'h80; i_a_im = 8'h80; i_b_re = 8'd10; i_b_im = -8'sd20;
        tick();
        i_start = 1'b0;
        check("k1 tw_start", o_tw_start, 1);
        check("k1 tw_c", $signed(o_tw_c), 91);
        check("k1 tw_cps", $signed(o_tw_c_plus_s), 0);
        check("k1 tw_cms", $signed(o_tw_c_minus_s), 182);
        check("k1 tw_x", $signed(o_tw_x), 10);
        check("k1 tw_y", $signed(o_tw_y), -20);
        tick();
        check("k1 tw_start width", o_tw_start, 0);
        i_start = 1'b1; i_k = 2'd3;
        i_a_re = 8'd1; i_a_im = 8'd1; i_b_re = 8'd33; i_b_im = 8'd44;
        tick();
        i_start = 1'b0;
        check("restart tw_start", o_tw_start, 0);
        check("restart tw_x", $signed(o_tw_x), 10);
        check("restart tw_y", $signed(o_tw_y), -20);
        check("restart tw_c", $signed(o_tw_c), 91);
        check("restart busy", o_busy, 1);
        // top = (-128-128)>>2 = -64, bot = (-128+128)>>2 = 0
        i_tw_valid = 1'b1; i_tw_re = 8'hC0; i_tw_im = 8'hC0;
        tick();
        i_tw_valid = 1'b0;
        check("k1 valid at tv", o_valid, 0);
        tick();
        check("k1 valid", o_valid, 1);
        check_results("k1", -64, -64, 0, 0);
        tick();
        check("k1 valid single", o_valid, 0);
        check("k1 busy done", o_busy, 0);

        // A stray i_tw_valid in IDLE must do nothing.
        i_tw_valid = 1'b1; i_tw_re = 8'd5; i_tw_im = 8'd5;
        tick();
        i_tw_valid = 1'b0;
        check("idle tw_valid busy", o_busy, 0);
        check("idle tw_valid valid", o_valid, 0);
        tick();
        check("idle tw_valid valid2", o_valid, 0);
        check_results("idle hold", -64, -64, 0, 0);

        // k=2, A=(1,0), tw=(-1,0): top = (1-2)>>2 = -1 (floor), bot = (1+2)>>2 = 0.
        i_start = 1'b1; i_k = 2'd2;
        i_a_re = 8'd1; i_a_im = 8'd0; i_b_re = 8'd0; i_b_im = 8'd0;
        tick();
        i_start = 1'b0;
        check("k2 tw_c", $signed(o_tw_c), 0);
        check("k2 tw_cps", $signed(o_tw_c_plus_s), -127);
        check("k2 tw_cms", $signed(o_tw_c_minus_s), 127);
        i_tw_valid = 1'b1; i_tw_re = 8'hFF; i_tw_im = 8'd0;
        tick();
        i_tw_valid = 1'b0;
        tick();
        check("k2 valid", o_valid, 1);
        check_results("k2", -1, 0, 0, 0);
        tick();

        // k=3, then reset while waiting for the multiplier.
        i_start = 1'b1; i_k = 2'd3;
        i_a_re = 8'd7; i_a_im = 8'd9; i_b_re = 8'd3; i_b_im = 8'd4;
        tick();
        i_start = 1'b0;
        check("k3 tw_c", $signed(o_tw_c), -91);
        check("k3 tw_cps", $signed(o_tw_c_plus_s), -182);
        check("k3 tw_cms", $signed(o_tw_c_minus_s), 0);
        tick();
        check("k3 busy wait", o_busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid rst busy", o_busy, 0);
        check("mid rst tw_x", $signed(o_tw_x), 0);
        check("mid rst tw_y", $signed(o_tw_y), 0);
        check("mid rst tw_c", $signed(o_tw_c), 0);
        check("mid rst tw_cms", $signed(o_tw_c_minus_s), 0);
        check("mid rst valid", o_valid, 0);
        check_results("mid rst", 0, 0, 0, 0);
        #1;
        rst_n = 1'b1;
        tick();
        i_tw_valid = 1'b1; i_tw_re = 8'd20; i_tw_im = 8'd20;
        tick();
        i_tw_valid = 1'b0;
        check("late tw_valid busy", o_busy, 0);
        check("late tw_valid valid", o_valid, 0);
        tick();
        check("late tw_valid valid2", o_valid, 0);
        check_results("late tw_valid", 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
